// File: rtl/l2_bridge_pkg.sv
// Shared types and helpers for the L2 bridge target adapter.
package l2_bridge_pkg;

    localparam int L2B_ID_W  = 9;
    localparam int L2B_AUX_W = 5;

    // Per-transaction tag carried from request to response.
    typedef struct packed {
        logic [L2B_ID_W-1:0]  id;
        logic [L2B_AUX_W-1:0] aux;
    } l2_bridge_tag_t;

    // Width of a counter that must reach 'depth' inclusive (depth is a power of two).
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/l2_bridge_fifo.sv
// Synchronous FIFO with an extra pointer bit to tell full from empty.
// The head is masked to zero while empty so downstream outputs read 0.
module l2_bridge_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_count   = r_wptr - r_rptr;
    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (o_count == FULL_CNT);
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;
    assign o_rdata   = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

    // Pointer update; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because the head is masked when empty.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/l2_bridge_target_adapter.sv
// Terminates one crossbar bridge port and drives a single in-order slave.
// Requests pass straight through under a credit limit; responses are
// buffered and returned in order together with the stored ID/aux tag.
module l2_bridge_target_adapter
    import l2_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int BE_WIDTH    = DATA_WIDTH/8,
    parameter int AUX_WIDTH   = L2B_AUX_W,
    parameter int ID_WIDTH    = L2B_ID_W,
    parameter int OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_req_i,
    input  logic [ADDR_WIDTH-1:0] data_add_i,
    input  logic                  data_wen_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_i,
    input  logic [BE_WIDTH-1:0]   data_be_i,
    input  logic [AUX_WIDTH-1:0]  data_aux_i,
    input  logic [ID_WIDTH-1:0]   data_ID_i,
    output logic                  data_gnt_o,
    output logic                  data_r_valid_o,
    input  logic                  data_r_gnt_i,
    output logic [DATA_WIDTH-1:0] data_r_rdata_o,
    output logic [AUX_WIDTH-1:0]  data_r_aux_o,
    output logic [ID_WIDTH-1:0]   data_r_ID_o,
    output logic                  per_req_o,
    output logic [ADDR_WIDTH-1:0] per_add_o,
    output logic                  per_wen_o,
    output logic [DATA_WIDTH-1:0] per_wdata_o,
    output logic [BE_WIDTH-1:0]   per_be_o,
    input  logic                  per_gnt_i,
    input  logic                  per_r_valid_i,
    input  logic [DATA_WIDTH-1:0] per_r_rdata_i,
    output logic                  err_o
);

    localparam int CW = cnt_width(OUTSTANDING);
    localparam logic [CW-1:0] MAX_CNT = CW'(OUTSTANDING);

    logic [CW-1:0]        r_inflight;
    logic                 r_err;
    logic                 w_credit_ok;
    logic                 w_pop;
    logic                 w_spurious;
    logic                 w_data_push;
    l2_bridge_tag_t       w_tag_in;
    l2_bridge_tag_t       w_tag_head;
    logic [DATA_WIDTH-1:0] w_data_head;
    logic [CW-1:0]        w_tag_cnt;
    logic [CW-1:0]        w_data_cnt;
    logic                 w_data_empty;
    logic                 w_tag_full;
    logic                 w_tag_empty;
    logic                 w_data_full;

    // Request path: combinational pass-through gated by the registered credit count.
    assign w_credit_ok = (r_inflight < MAX_CNT);
    assign per_req_o   = data_req_i & w_credit_ok & ~rst;
    assign data_gnt_o  = per_req_o & per_gnt_i;
    assign per_add_o   = data_add_i;
    assign per_wen_o   = data_wen_i;
    assign per_wdata_o = data_wdata_i;
    assign per_be_o    = data_be_i;

    assign w_tag_in.id  = data_ID_i;
    assign w_tag_in.aux = data_aux_i;

    // A response beat is only legal while a request is still waiting at the slave.
    assign w_spurious  = per_r_valid_i & (w_data_cnt == w_tag_cnt);
    assign w_data_push = per_r_valid_i & ~w_spurious;

    // Response path: valid follows the data FIFO; tag head is masked until data arrives.
    assign data_r_valid_o = ~w_data_empty;
    assign w_pop          = data_r_valid_o & data_r_gnt_i;
    assign data_r_rdata_o = w_data_head;
    assign data_r_ID_o    = data_r_valid_o ? w_tag_head.id  : '0;
    assign data_r_aux_o   = data_r_valid_o ? w_tag_head.aux : '0;
    assign err_o          = r_err;

    l2_bridge_fifo #(
        .WIDTH ($bits(l2_bridge_tag_t)),
        .DEPTH (OUTSTANDING)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (data_gnt_o),
        .i_wdata (w_tag_in),
        .i_pop   (w_pop),
        .o_rdata (w_tag_head),
        .o_full  (w_tag_full),
        .o_empty (w_tag_empty),
        .o_count (w_tag_cnt)
    );

    l2_bridge_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (OUTSTANDING)
    ) u_data_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_data_push),
        .i_wdata (per_r_rdata_i),
        .i_pop   (w_pop),
        .o_rdata (w_data_head),
        .o_full  (w_data_full),
        .o_empty (w_data_empty),
        .o_count (w_data_cnt)
    );

    // In-flight credit counter: grant adds one, response pop frees one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= '0;
        end else begin
            case ({data_gnt_o, w_pop})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // Sticky protocol error on unsolicited response beats.
    always_ff @(posedge clk) begin
        if (rst) r_err <= 1'b0;
        else if (w_spurious) r_err <= 1'b1;
    end

    // Full/empty of the helper FIFOs are implied by the credit scheme and unused here.
    logic w_unused;
    assign w_unused = w_tag_full ^ w_tag_empty ^ w_data_full;

endmodule

// File: tb/tb_l2_bridge_target_adapter.sv
// Directed bench for l2_bridge_target_adapter with the slave modelled by hand.
module tb_l2_bridge_target_adapter;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_req_i;
    logic [31:0] data_add_i;
    logic        data_wen_i;
    logic [31:0] data_wdata_i;
    logic [3:0]  data_be_i;
    logic [4:0]  data_aux_i;
    logic [8:0]  data_ID_i;
    logic        data_gnt_o;
    logic        data_r_valid_o;
    logic        data_r_gnt_i;
    logic [31:0] data_r_rdata_o;
    logic [4:0]  data_r_aux_o;
    logic [8:0]  data_r_ID_o;
    logic        per_req_o;
    logic [31:0] per_add_o;
    logic        per_wen_o;
    logic [31:0] per_wdata_o;
    logic [3:0]  per_be_o;
    logic        per_gnt_i;
    logic        per_r_valid_i;
    logic [31:0] per_r_rdata_i;
    logic        err_o;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    l2_bridge_target_adapter dut (
        .clk            (clk),
        .rst            (rst),
        .data_req_i     (data_req_i),
        .data_add_i     (data_add_i),
        .data_wen_i     (data_wen_i),
        .data_wdata_i   (data_wdata_i),
        .data_be_i      (data_be_i),
        .data_aux_i     (data_aux_i),
        .data_ID_i      (data_ID_i),
        .data_gnt_o     (data_gnt_o),
        .data_r_valid_o (data_r_valid_o),
        .data_r_gnt_i   (data_r_gnt_i),
        .data_r_rdata_o (data_r_rdata_o),
        .data_r_aux_o   (data_r_aux_o),
        .data_r_ID_o    (data_r_ID_o),
        .per_req_o      (per_req_o),
        .per_add_o      (per_add_o),
        .per_wen_o      (per_wen_o),
        .per_wdata_o    (per_wdata_o),
        .per_be_o       (per_be_o),
        .per_gnt_i      (per_gnt_i),
        .per_r_valid_i  (per_r_valid_i),
        .per_r_rdata_i  (per_r_rdata_i),
        .err_o          (err_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_resp(input string tag, input logic [31:0] rd, input logic [8:0] id,
                            input logic [4:0] aux);
        chk({tag, ".valid"}, 32'(data_r_valid_o), 32'd1);
        chk({tag, ".rdata"}, data_r_rdata_o, rd);
        chk({tag, ".id"},    32'(data_r_ID_o), 32'(id));
        chk({tag, ".aux"},   32'(data_r_aux_o), 32'(aux));
    endtask

    initial begin
        rst = 1'b1; data_req_i = 1'b0; data_add_i = '0; data_wen_i = 1'b0;
        data_wdata_i = '0; data_be_i = '0; data_aux_i = '0; data_ID_i = '0;
        data_r_gnt_i = 1'b0; per_gnt_i = 1'b0; per_r_valid_i = 1'b0; per_r_rdata_i = '0;
        tick(); tick();

        // Reset state: requests blocked while rst is high, outputs zero.
        data_req_i = 1'b1; per_gnt_i = 1'b1;
        #1;
        chk("rst.per_req", 32'(per_req_o), 32'd0);
        chk("rst.gnt",     32'(data_gnt_o), 32'd0);
        chk("rst.rvalid",  32'(data_r_valid_o), 32'd0);
        chk("rst.err",     32'(err_o), 32'd0);
        chk("rst.rdata",   data_r_rdata_o, 32'd0);
        chk("rst.id",      32'(data_r_ID_o), 32'd0);
        chk("rst.aux",     32'(data_r_aux_o), 32'd0);
        data_req_i = 1'b0; per_gnt_i = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Single load, response 3 cycles after the grant.
        data_req_i = 1'b1; data_add_i = 32'h1A00_0010; data_wen_i = 1'b1;
        data_wdata_i = 32'h0123_4567; data_be_i = 4'hF;
        data_ID_i = 9'h004; data_aux_i = 5'h3; per_gnt_i = 1'b1;
        #1;
        chk("load.per_req", 32'(per_req_o), 32'd1);
        chk("load.gnt",     32'(data_gnt_o), 32'd1);
        chk("load.add",     per_add_o, 32'h1A00_0010);
        chk("load.wen",     32'(per_wen_o), 32'd1);
        chk("load.wdata",   per_wdata_o, 32'h0123_4567);
        chk("load.be",      32'(per_be_o), 32'hF);
        tick();
        data_req_i = 1'b0; per_gnt_i = 1'b0;
        tick(); tick();
        per_r_valid_i = 1'b1; per_r_rdata_i = 32'hDEAD_BEEF;
        #1;
        chk("load.early", 32'(data_r_valid_o), 32'd0);
        tick();
        per_r_valid_i = 1'b0;
        chk_resp("load.resp", 32'hDEAD_BEEF, 9'h004, 5'h3);
        data_r_gnt_i = 1'b1;
        tick();
        data_r_gnt_i = 1'b0;
        chk("load.popped", 32'(data_r_valid_o), 32'd0);

        // Credit saturation: four grants, then the request is blocked.
        data_req_i = 1'b1; per_gnt_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_ID_i = 9'(1 << i); data_aux_i = 5'(8 + i);
            #1;
            chk("sat.gnt", 32'(data_gnt_o), 32'd1);
            tick();
        end
        data_ID_i = 9'h100; data_aux_i = 5'h1F;
        chk("sat.blocked", 32'(per_req_o), 32'd0);
        chk("sat.nogrant", 32'(data_gnt_o), 32'd0);

        // Slave returns three responses back to back while the crossbar stalls.
        for (int i = 0; i < 3; i++) begin
            per_r_valid_i = 1'b1; per_r_rdata_i = 32'h1000_0000 + 32'(i);
            tick();
        end
        per_r_valid_i = 1'b0;

        // Backpressure: head stays put for 10 cycles, credit stays exhausted.
        for (int i = 0; i < 10; i++) begin
            chk_resp("bp.head", 32'h1000_0000, 9'h001, 5'h8);
            chk("bp.blocked", 32'(per_req_o), 32'd0);
            tick();
        end

        // Release: pop in this cycle must not unblock the request until next cycle.
        data_r_gnt_i = 1'b1;
        #1;
        chk("rel.still_blocked", 32'(per_req_o), 32'd0);
        chk_resp("rel.pop0", 32'h1000_0000, 9'h001, 5'h8);
        tick();
        // inflight == 3: grant and pop together keep the count at 3.
        chk("rel.reenabled", 32'(per_req_o), 32'd1);
        chk("rel.gnt_a", 32'(data_gnt_o), 32'd1);
        chk_resp("rel.pop1", 32'h1000_0001, 9'h002, 5'h9);
        tick();
        data_ID_i = 9'h080; data_aux_i = 5'h11;
        #1;
        chk("sim.accept", 32'(data_gnt_o), 32'd1);
        chk_resp("rel.pop2", 32'h1000_0002, 9'h004, 5'hA);
        tick();
        data_req_i = 1'b0; per_gnt_i = 1'b0;

        // Drain the remaining three in order; each pops the cycle it appears.
        per_r_valid_i = 1'b1; per_r_rdata_i = 32'h1000_0003;
        #1;
        chk("drain.empty", 32'(data_r_valid_o), 32'd0);
        tick();
        per_r_rdata_i = 32'h2000_0005;
        chk_resp("drain.r3", 32'h1000_0003, 9'h008, 5'hB);
        tick();
        per_r_rdata_i = 32'h2000_0006;
        chk_resp("drain.r5", 32'h2000_0005, 9'h100, 5'h1F);
        tick();
        per_r_valid_i = 1'b0;
        chk_resp("drain.r6", 32'h2000_0006, 9'h080, 5'h11);
        tick();
        chk("drain.done", 32'(data_r_valid_o), 32'd0);
        chk("drain.noerr", 32'(err_o), 32'd0);

        // Spurious response with nothing outstanding.
        per_r_valid_i = 1'b1; per_r_rdata_i = 32'h5555_5555;
        tick();
        per_r_valid_i = 1'b0;
        chk("spur.err", 32'(err_o), 32'd1);
        chk("spur.rvalid", 32'(data_r_valid_o), 32'd0);
        tick(); tick();
        chk("spur.sticky", 32'(err_o), 32'd1);
        chk("spur.rvalid2", 32'(data_r_valid_o), 32'd0);

        // Reset with two in flight.
        data_req_i = 1'b1; per_gnt_i = 1'b1;
        data_ID_i = 9'h010; data_aux_i = 5'h4;
        tick();
        data_ID_i = 9'h020; data_aux_i = 5'h5;
        tick();
        data_req_i = 1'b0; per_gnt_i = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst.rvalid", 32'(data_r_valid_o), 32'd0);
        chk("mrst.err", 32'(err_o), 32'd0);

        // Fresh load after reset.
        data_req_i = 1'b1; per_gnt_i = 1'b1; data_add_i = 32'h1A00_0020;
        data_ID_i = 9'h040; data_aux_i = 5'h6;
        #1;
        chk("fresh.gnt", 32'(data_gnt_o), 32'd1);
        tick();
        data_req_i = 1'b0; per_gnt_i = 1'b0;
        per_r_valid_i = 1'b1; per_r_rdata_i = 32'hCAFE_F00D;
        tick();
        per_r_valid_i = 1'b0;
        chk_resp("fresh.resp", 32'hCAFE_F00D, 9'h040, 5'h6);
        tick();
        chk("fresh.popped", 32'(data_r_valid_o), 32'd0);
        chk("fresh.noerr", 32'(err_o), 32'd0);

        // Full credit available after reset: four grants, fifth blocked.
        data_r_gnt_i = 1'b0;
        data_req_i = 1'b1; per_gnt_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("post.gnt", 32'(data_gnt_o), 32'd1);
            tick();
        end
        chk("post.blocked", 32'(per_req_o), 32'd0);
        data_req_i = 1'b0; per_gnt_i = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
